// File: rtl/selsort_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : selsort_pkg                                                     |
// | Purpose  : Shared state encoding and default sizing for the selection-sort |
// |            controller and its running-maximum tracker.                     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package selsort_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_SWAP_A = 3'd3;
  localparam logic [2:0] ST_SWAP_B = 3'd4;
  localparam logic [2:0] ST_SWAP_C = 3'd5;
  localparam logic [2:0] ST_NEXT   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    SCAN   = ST_SCAN,
    SWAP_A = ST_SWAP_A,
    SWAP_B = ST_SWAP_B,
    SWAP_C = ST_SWAP_C,
    NEXT   = ST_NEXT,
    DONE   = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/selsort_controller_max_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : max_tracker                                                     |
// | Purpose  : Holds the running maximum value and its index for one pass of  |
// |            the find-max scan.                                              |
// | Ports    : clk, rst   - clock, synchronous active-high reset               |
// |            load       - seed max_val/max_i from data/idx                   |
// |            update     - replace when data is strictly greater              |
// |            idx, data  - candidate index and value                          |
// |            max_val, max_i - current maximum and its index                  |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module max_tracker
  import selsort_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          update,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  data,
  output logic [W-1:0]  max_val,
  output logic [AW-1:0] max_i
);

  // Strict compare: on a tie the earlier (lower) index is kept.
  logic greater;
  assign greater = (data > max_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val <= '0;
      max_i   <= '0;
    end else if (load) begin
      max_val <= data;
      max_i   <= idx;
    end else if (update && greater) begin
      max_val <= data;
      max_i   <= idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/selsort_controller.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : selsort_controller                                              |
// | Purpose  : Sequences an in-place descending selection sort over an N-entry |
// |            register file: find-max scan of A[i..N-1], then swap into A[i]. |
// | Ports    : clk, rst  - clock, synchronous active-high reset                |
// |            start     - begin sort (sampled only when idle)                 |
// |            busy      - sort in progress, through the done cycle            |
// |            done      - one-cycle completion pulse                          |
// |            rd_addr / rd_data - combinational register-file read            |
// |            wr_en / wr_addr / wr_data - register-file write (next edge)     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module selsort_controller
  import selsort_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data
);

  localparam logic [AW-1:0] ONE    = AW'(1);
  localparam logic [AW-1:0] LAST   = AW'(N - 1);
  localparam logic [AW-1:0] PENULT = AW'(N - 2);

  state_t        state;
  logic [AW-1:0] i;
  logic [AW-1:0] j;
  logic [W-1:0]  tmp;
  logic [W-1:0]  max_val;
  logic [AW-1:0] max_i;

  logic          trk_load;
  logic          trk_update;
  logic [AW-1:0] trk_idx;

  // LOAD seeds the tracker with A[i]; SCAN offers A[j] as a candidate.
  assign trk_load   = (state == LOAD);
  assign trk_update = (state == SCAN);
  assign trk_idx    = (state == LOAD) ? i : j;

  max_tracker #(
    .W  (W),
    .AW (AW)
  ) u_max_tracker (
    .clk     (clk),
    .rst     (rst),
    .load    (trk_load),
    .update  (trk_update),
    .idx     (trk_idx),
    .data    (rd_data),
    .max_val (max_val),
    .max_i   (max_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      tmp   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i     <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          j     <= i + ONE;
          state <= SCAN;
        end
        SCAN: begin
          if (j == LAST) begin
            state <= SWAP_A;
          end else begin
            j <= j + ONE;
          end
        end
        SWAP_A: begin
          // Maximum already in place: skip both write cycles.
          tmp   <= rd_data;
          state <= (max_i == i) ? NEXT : SWAP_B;
        end
        SWAP_B: state <= SWAP_C;
        SWAP_C: state <= NEXT;
        NEXT: begin
          if (i == PENULT) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i     <= i + ONE;
            state <= LOAD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath controls are a pure decode of registered state and counters.
  always_comb begin
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      LOAD:   rd_addr = i;
      SCAN:   rd_addr = j;
      SWAP_A: rd_addr = i;
      SWAP_B: begin
        wr_en   = 1'b1;
        wr_addr = max_i;
        wr_data = tmp;
      end
      SWAP_C: begin
        wr_en   = 1'b1;
        wr_addr = i;
        wr_data = max_val;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_selsort_controller.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_selsort_controller                                           |
// | Purpose  : Self-checking bench for selsort_controller with a bench-owned  |
// |            register file and a behavioural selection-sort reference.       |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_selsort_controller;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int AW = 3;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef logic [1:0][W-1:0]   vec2_t;

  typedef struct {
    vec_t a;
    vec_t exp;
    int   cyc;
    int   wr;
  } vec_rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  logic          start2;
  logic          busy2;
  logic          done2;
  logic [0:0]    rd_addr2;
  logic [W-1:0]  rd_data2;
  logic          wr_en2;
  logic [0:0]    wr_addr2;
  logic [W-1:0]  wr_data2;

  vec_t  mem;
  vec_t  load_vals;
  logic  load_en;
  vec2_t mem2;
  vec2_t load2_vals;
  logic  load2_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  selsort_controller #(.N(N), .W(W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  selsort_controller #(.N(2), .W(W)) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .busy    (busy2),
    .done    (done2),
    .rd_addr (rd_addr2),
    .rd_data (rd_data2),
    .wr_en   (wr_en2),
    .wr_addr (wr_addr2),
    .wr_data (wr_data2)
  );

  // Bench register files: combinational read, write on the next edge.
  assign rd_data  = mem[rd_addr];
  assign rd_data2 = mem2[rd_addr2];

  always_ff @(posedge clk) begin
    if (load_en)    mem <= load_vals;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (load2_en)    mem2 <= load2_vals;
    else if (wr_en2) mem2[wr_addr2] <= wr_data2;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input int e0, e1, e2, e3, e4, e5, e6, e7);
    vec_t v;
    v[0] = W'(e0); v[1] = W'(e1); v[2] = W'(e2); v[3] = W'(e3);
    v[4] = W'(e4); v[5] = W'(e5); v[6] = W'(e6); v[7] = W'(e7);
    return v;
  endfunction

  // Reference: descending selection sort, first maximum wins, count swaps.
  function automatic void model(input vec_t a, output vec_t s, output int swaps);
    int x[N];
    int m;
    int t;
    for (int k = 0; k < N; k++) x[k] = int'(a[k]);
    swaps = 0;
    for (int p = 0; p < N - 1; p++) begin
      m = p;
      for (int q = p + 1; q < N; q++) if (x[q] > x[m]) m = q;
      if (m != p) begin
        t = x[p]; x[p] = x[m]; x[m] = t;
        swaps++;
      end
    end
    for (int k = 0; k < N; k++) s[k] = W'(x[k]);
  endfunction

  task automatic run_sort(input string nm, input vec_t init, input vec_t req,
                          input int req_cyc, input int req_wr);
    int cyc;
    int wr;
    bit seen;
    @(negedge clk); load_vals = init; load_en = 1'b1;
    @(negedge clk); load_en = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk($sformatf("%s_busy_rise", nm), 64'(busy), 64'd1);
    cyc = -1; wr = 0; seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      if (wr_en) wr++;
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; cyc = c; end
    end
    chk($sformatf("%s_done_edge", nm), 64'(cyc), 64'(req_cyc));
    chk($sformatf("%s_writes", nm), 64'(wr), 64'(req_wr));
    @(posedge clk); #1;
    chk($sformatf("%s_done_pulse", nm), 64'(done), 64'd0);
    chk($sformatf("%s_busy_fall", nm), 64'(busy), 64'd0);
    chk($sformatf("%s_contents", nm), 64'(mem), 64'(req));
  endtask

  task automatic run_sort2(input string nm, input vec2_t init, input vec2_t req,
                           input int req_cyc, input int req_wr);
    int cyc;
    int wr;
    bit seen;
    @(negedge clk); load2_vals = init; load2_en = 1'b1;
    @(negedge clk); load2_en = 1'b0; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    cyc = -1; wr = 0; seen = 1'b0;
    for (int c = 1; c <= 50 && !seen; c++) begin
      if (wr_en2) wr++;
      @(posedge clk); #1;
      if (done2) begin seen = 1'b1; cyc = c; end
    end
    chk($sformatf("%s_done_edge", nm), 64'(cyc), 64'(req_cyc));
    chk($sformatf("%s_writes", nm), 64'(wr), 64'(req_wr));
    @(posedge clk); #1;
    chk($sformatf("%s_busy_fall", nm), 64'(busy2), 64'd0);
    chk($sformatf("%s_contents", nm), 64'(mem2), 64'(req));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_rec_t tbl[4];
    vec_t     a;
    vec_t     s;
    vec2_t    v2a;
    vec2_t    v2e;
    int       sw;
    int       cyc;
    int       wr;
    bit       seen;

    tbl[0].a = mk(3, 7, 1, 9, 0, 5, 2, 8); tbl[0].exp = mk(9, 8, 7, 5, 3, 2, 1, 0);
    tbl[0].cyc = 63; tbl[0].wr = 14;
    tbl[1].a = mk(7, 6, 5, 4, 3, 2, 1, 0); tbl[1].exp = mk(7, 6, 5, 4, 3, 2, 1, 0);
    tbl[1].cyc = 49; tbl[1].wr = 0;
    tbl[2].a = mk(0, 1, 2, 3, 4, 5, 6, 7); tbl[2].exp = mk(7, 6, 5, 4, 3, 2, 1, 0);
    tbl[2].cyc = 57; tbl[2].wr = 8;
    tbl[3].a = mk(85, 85, 85, 85, 85, 85, 85, 85); tbl[3].exp = tbl[3].a;
    tbl[3].cyc = 49; tbl[3].wr = 0;

    rst = 1'b1; start = 1'b0; load_en = 1'b0; load_vals = '0;
    start2 = 1'b0; load2_en = 1'b0; load2_vals = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",    64'(busy),    64'd0);
    chk("reset_done",    64'(done),    64'd0);
    chk("reset_wr_en",   64'(wr_en),   64'd0);
    chk("reset_rd_addr", 64'(rd_addr), 64'd0);
    chk("reset_wr_addr", 64'(wr_addr), 64'd0);
    chk("reset_wr_data", 64'(wr_data), 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int t = 0; t < 4; t++)
      run_sort($sformatf("tbl%0d", t), tbl[t].a, tbl[t].exp, tbl[t].cyc, tbl[t].wr);

    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < N; k++) a[k] = W'($urandom_range(0, (t < 6) ? 15 : 255));
      model(a, s, sw);
      run_sort($sformatf("rand%0d", t), a, s, 49 + 2 * sw, 2 * sw);
    end

    // Reset while the first write of pass 0 is on the bus.
    @(negedge clk); load_vals = tbl[0].a; load_en = 1'b1;
    @(negedge clk); load_en = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (wr_en) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("abort_reach_swap_b", 64'(seen), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_wr_en", 64'(wr_en), 64'd0);
    chk("abort_busy",  64'(busy),  64'd0);
    chk("abort_done",  64'(done),  64'd0);
    @(negedge clk); rst = 1'b0;
    wr = 0;
    repeat (5) begin @(posedge clk); #1; if (wr_en || busy) wr++; end
    chk("abort_stays_idle", 64'(wr), 64'd0);
    chk("abort_partial", 64'(mem), 64'(mk(3, 7, 1, 3, 0, 5, 2, 8)));
    a = mem;
    model(a, s, sw);
    run_sort("abort_resort", a, s, 49 + 2 * sw, 2 * sw);

    // start held high: ignored while busy, re-triggers from IDLE only.
    @(negedge clk); load_vals = mk(0, 1, 2, 3, 4, 5, 6, 7); load_en = 1'b1;
    @(negedge clk); load_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    cyc = -1; wr = 0; seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      if (wr_en) wr++;
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; cyc = c; end
    end
    chk("hold_first_edge",   64'(cyc), 64'd57);
    chk("hold_first_writes", 64'(wr),  64'd8);
    @(posedge clk); #1;
    chk("hold_idle_gap", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("hold_retrigger", 64'(busy), 64'd1);
    cyc = -1; wr = 0; seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      if (wr_en) wr++;
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; cyc = c; end
    end
    start = 1'b0;
    chk("hold_second_edge",   64'(cyc), 64'd49);
    chk("hold_second_writes", 64'(wr),  64'd0);
    wr = 0;
    repeat (4) begin @(posedge clk); #1; if (busy) wr++; end
    chk("hold_released_idle", 64'(wr), 64'd0);
    chk("hold_contents", 64'(mem), 64'(mk(7, 6, 5, 4, 3, 2, 1, 0)));

    // Two-entry instance: single pass, one SCAN cycle.
    v2a[0] = W'(1); v2a[1] = W'(3);
    v2e[0] = W'(3); v2e[1] = W'(1);
    run_sort2("n2_swap", v2a, v2e, 6, 2);
    run_sort2("n2_sorted", v2e, v2e, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
